// File: rtl/mem_access_pkg.sv
// Shared types and constants for the CPU-side load/store unit.
// Split-access states exist only when MEM_SPLIT_MISALIGNED_EN is defined.
package mem_access_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_DATA
`ifdef MEM_SPLIT_MISALIGNED_EN
    ,
    S_LD_LO,
    S_LD_HI,
    S_ST_HI
`endif
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = MASK_B;
      2'b01:   size_mask = MASK_H;
      2'b10:   size_mask = MASK_W;
      default: size_mask = '0;
    endcase
  endfunction

  // Unsigned variants exist only for loads; 011/110/111 are never legal.
  function automatic logic funct3_bad(input logic [2:0] f3, input logic write);
    funct3_bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (write && f3[2]);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Word-addressed data memory port with per-byte write enables.
interface data_memory_if;
  logic [3:0]  WriteEnable;
  logic [11:2] addr_out;
  logic [31:0] data_out;
  logic [31:0] data_in;

  modport cpu (output WriteEnable, output addr_out, output data_out, input data_in);
  modport mem (input WriteEnable, input addr_out, input data_out, output data_in);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: byte-lane mask, 64-bit store image, word
// crossing detect, and extraction/extension of load data from a 64-bit image.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rimage,
  output logic [7:0]  lane_mask,
  output logic [63:0] store_image,
  output logic        crossing,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    lane_mask   = {4'b0000, size_mask(funct3)} << off;
    store_image = {32'h0, wdata} << {off, 3'b000};
    crossing    = |lane_mask[7:4];
    shifted     = rimage[{off, 3'b000} +: 32];
    case (funct3_e'(funct3))
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      F3_W:    load_data = shifted;
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller between MEM stage and data memory.
// Define MEM_SPLIT_MISALIGNED_EN to split word-crossing accesses; otherwise they fault.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        fault,
  data_memory_if.cpu  dmem
);

  state_e      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [9:0]  lat_word;
  logic [31:0] lat_wdata;
  logic [9:0]  word_next;

  logic        in_idle;
  logic        accept;
  logic        req_bad;
  logic        req_reject;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_off;
  logic [31:0] sel_wdata;
  logic [63:0] rimage;
  logic [7:0]  lane_mask;
  logic [63:0] store_image;
  logic        crossing;
  logic [31:0] load_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:12];

  assign in_idle   = (state == S_IDLE);
  assign req_ready = in_idle && !rst;
  assign accept    = req_valid && req_ready;
  assign req_bad   = funct3_bad(req_funct3, req_write);
  assign word_next = lat_word + 10'd1;

  // Idle cycles steer the live request; busy cycles steer the latched one.
  assign sel_funct3 = in_idle ? req_funct3     : lat_funct3;
  assign sel_off    = in_idle ? req_addr[1:0]  : lat_off;
  assign sel_wdata  = in_idle ? req_wdata      : lat_wdata;

`ifdef MEM_SPLIT_MISALIGNED_EN
  logic [31:0] lo_reg;
  assign rimage     = (state == S_LD_HI) ? {dmem.data_in, lo_reg} : {32'h0, dmem.data_in};
  assign req_reject = req_bad;
`else
  assign rimage     = {32'h0, dmem.data_in};
  assign req_reject = req_bad || crossing;
`endif

  mem_lane_align u_align (
    .funct3      (sel_funct3),
    .off         (sel_off),
    .wdata       (sel_wdata),
    .rimage      (rimage),
    .lane_mask   (lane_mask),
    .store_image (store_image),
    .crossing    (crossing),
    .load_data   (load_data)
  );

  // Gated by rst so an aborted high-half store never reaches memory.
  always_comb begin
    dmem.WriteEnable = '0;
    dmem.addr_out    = '0;
    dmem.data_out    = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (accept && !req_reject) begin
            dmem.addr_out = req_addr[11:2];
            if (req_write) begin
              dmem.WriteEnable = lane_mask[3:0];
              dmem.data_out    = store_image[31:0];
            end
          end
        end
`ifdef MEM_SPLIT_MISALIGNED_EN
        S_LD_LO: dmem.addr_out = word_next;
        S_ST_HI: begin
          dmem.WriteEnable = lane_mask[7:4];
          dmem.addr_out    = word_next;
          dmem.data_out    = store_image[63:32];
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      lat_funct3  <= '0;
      lat_off     <= '0;
      lat_word    <= '0;
      lat_wdata   <= '0;
`ifdef MEM_SPLIT_MISALIGNED_EN
      lo_reg      <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_word   <= req_addr[11:2];
            lat_wdata  <= req_wdata;
            if (req_reject)
              fault <= 1'b1;
`ifdef MEM_SPLIT_MISALIGNED_EN
            else if (crossing)
              state <= req_write ? S_ST_HI : S_LD_LO;
`endif
            else if (!req_write)
              state <= S_LD_DATA;
          end
        end
        S_LD_DATA: begin
          rdata       <= load_data;
          rdata_valid <= 1'b1;
          state       <= S_IDLE;
        end
`ifdef MEM_SPLIT_MISALIGNED_EN
        S_LD_LO: begin
          lo_reg <= dmem.data_in;
          state  <= S_LD_HI;
        end
        S_LD_HI: begin
          rdata       <= load_data;
          rdata_valid <= 1'b1;
          state       <= S_IDLE;
        end
        S_ST_HI: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model;
// expectations follow MEM_SPLIT_MISALIGNED_EN when it is defined.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        fault;

  data_memory_if dmem_if ();

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .fault       (fault),
    .dmem        (dmem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: byte-enabled writes, one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    dmem_if.data_in <= mem[dmem_if.addr_out];
    for (int b = 0; b < 4; b++)
      if (dmem_if.WriteEnable[b])
        mem[dmem_if.addr_out][8*b +: 8] <= dmem_if.data_out[8*b +: 8];
  end

  // Reference model: flat 4 KiB byte space.
  logic [7:0] rmem [4096];

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_bad;
  logic        exp_cross;
  logic [31:0] exp_rd;

  logic [3:0]  c_we  [4];
  logic [9:0]  c_ad  [4];
  logic [31:0] c_do  [4];
  logic        c_rv  [4];
  logic        c_fl  [4];
  logic        c_rdy [4];
  logic [31:0] c_rd  [4];

  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int unsigned size;
    int unsigned off;
    int unsigned base;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = a[1:0];
    base = a[11:0];
    exp_bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && f3[2]);
    exp_cross = !exp_bad && (off + size > 4);
`ifndef MEM_SPLIT_MISALIGNED_EN
    if (exp_cross) exp_bad = 1'b1;
`endif
    exp_rd = '0;
    if (!exp_bad) begin
      if (w) begin
        for (int unsigned i = 0; i < size; i++)
          rmem[(base + i) % 4096] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < size; i++)
          v = v | (32'(rmem[(base + i) % 4096]) << (8*i));
        case (f3)
          3'd0:    exp_rd = {{24{v[7]}}, v[7:0]};
          3'd1:    exp_rd = {{16{v[15]}}, v[15:0]};
          default: exp_rd = v;
        endcase
      end
    end
  endtask

  task automatic sample(input int k);
    c_we[k]  = dmem_if.WriteEnable;
    c_ad[k]  = dmem_if.addr_out;
    c_do[k]  = dmem_if.data_out;
    c_rv[k]  = rdata_valid;
    c_fl[k]  = fault;
    c_rdy[k] = req_ready;
    c_rd[k]  = rdata;
  endtask

  // Called and returns at posedge+1; index k of c_* is k edges after the accept cycle.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int unsigned n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_wait got %b exp 1", req_ready);
    else n_pass++;
    model(w, f3, a, wd);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1 sample(0);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    #1 sample(1);
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      sample(k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b0 || dmem_if.WriteEnable !== 4'h0)
        $display("FAIL reset_hold got ready=%b we=%h exp ready=0 we=0", req_ready, dmem_if.WriteEnable);
      else n_pass++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0 || fault !== 1'b0)
      $display("FAIL reset_regs got rdata=%h rv=%b fault=%b exp 0/0/0", rdata, rdata_valid, fault);
    else n_pass++;
    n_checks++;
    if (dmem_if.WriteEnable !== 4'h0 || dmem_if.addr_out !== 10'h0 || dmem_if.data_out !== 32'h0)
      $display("FAIL reset_mem got we=%h addr=%h data=%h exp 0/0/0",
               dmem_if.WriteEnable, dmem_if.addr_out, dmem_if.data_out);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_aligned;
    issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    n_checks++;
    if (c_we[0] !== 4'b1111 || c_ad[0] !== 10'h004 || c_do[0] !== 32'hDEAD_BEEF)
      $display("FAIL sw_issue got we=%b addr=%h data=%h exp 1111/004/deadbeef", c_we[0], c_ad[0], c_do[0]);
    else n_pass++;
    n_checks++;
    if (c_rdy[1] !== 1'b1 || c_we[1] !== 4'h0)
      $display("FAIL sw_next got ready=%b we=%h exp 1/0", c_rdy[1], c_we[1]);
    else n_pass++;
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    n_checks++;
    if (c_rv[1] !== 1'b0 || c_rv[2] !== 1'b1 || c_rd[2] !== 32'hDEAD_BEEF)
      $display("FAIL lw_result got rv1=%b rv2=%b rdata=%h exp 0/1/deadbeef", c_rv[1], c_rv[2], c_rd[2]);
    else n_pass++;
    n_checks++;
    if (c_rdy[1] !== 1'b0 || c_rdy[2] !== 1'b1)
      $display("FAIL lw_throughput got rdy1=%b rdy2=%b exp 0/1", c_rdy[1], c_rdy[2]);
    else n_pass++;
  endtask

  task automatic test_byte_half;
    issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080);
    n_checks++;
    if (c_we[0] !== 4'b1000 || c_do[0][31:24] !== 8'h80)
      $display("FAIL sb_lane got we=%b byte=%h exp 1000/80", c_we[0], c_do[0][31:24]);
    else n_pass++;
    issue(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'hFFFF_FF80) $display("FAIL lb_sext got %h exp ffffff80", c_rd[2]);
    else n_pass++;
    issue(1'b0, 3'b100, 32'h0000_0013, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'h0000_0080) $display("FAIL lbu_zext got %h exp 00000080", c_rd[2]);
    else n_pass++;
    issue(1'b1, 3'b001, 32'h0000_0021, 32'h0000_A55A);
    n_checks++;
    if (c_we[0] !== 4'b0110 || c_we[1] !== 4'h0 || c_do[0][23:8] !== 16'hA55A)
      $display("FAIL sh_mid got we0=%b we1=%b half=%h exp 0110/0000/a55a", c_we[0], c_we[1], c_do[0][23:8]);
    else n_pass++;
    issue(1'b0, 3'b001, 32'h0000_0021, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'hFFFF_A55A) $display("FAIL lh_mid got %h exp ffffa55a", c_rd[2]);
    else n_pass++;
  endtask

  task automatic test_crossing;
    issue(1'b1, 3'b010, 32'h0000_00FE, 32'h1122_3344);
`ifdef MEM_SPLIT_MISALIGNED_EN
    n_checks++;
    if (c_we[0] !== 4'b1100 || c_ad[0] !== 10'h03F || c_we[1] !== 4'b0011 || c_ad[1] !== 10'h040)
      $display("FAIL sw_split got we0=%b a0=%h we1=%b a1=%h exp 1100/03f/0011/040",
               c_we[0], c_ad[0], c_we[1], c_ad[1]);
    else n_pass++;
    n_checks++;
    if (c_rdy[1] !== 1'b0 || c_rdy[2] !== 1'b1)
      $display("FAIL sw_split_busy got rdy1=%b rdy2=%b exp 0/1", c_rdy[1], c_rdy[2]);
    else n_pass++;
    issue(1'b0, 3'b010, 32'h0000_00FE, 32'h0);
    n_checks++;
    if (c_rv[2] !== 1'b0 || c_rv[3] !== 1'b1 || c_rd[3] !== 32'h1122_3344)
      $display("FAIL lw_split got rv2=%b rv3=%b rdata=%h exp 0/1/11223344", c_rv[2], c_rv[3], c_rd[3]);
    else n_pass++;
`else
    n_checks++;
    if (c_fl[1] !== 1'b1 || c_we[0] !== 4'h0)
      $display("FAIL sw_cross_fault got fault=%b we=%b exp 1/0000", c_fl[1], c_we[0]);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap;
    issue(1'b1, 3'b000, 32'h0000_0FFF, 32'h0000_0034);
    issue(1'b1, 3'b000, 32'h0000_0000, 32'h0000_0012);
    issue(1'b0, 3'b101, 32'h0000_0FFF, 32'h0);
`ifdef MEM_SPLIT_MISALIGNED_EN
    n_checks++;
    if (c_ad[0] !== 10'h3FF || c_ad[1] !== 10'h000)
      $display("FAIL wrap_addr got a0=%h a1=%h exp 3ff/000", c_ad[0], c_ad[1]);
    else n_pass++;
    n_checks++;
    if (c_rv[3] !== 1'b1 || c_rd[3] !== 32'h0000_1234)
      $display("FAIL wrap_lhu got rv=%b rdata=%h exp 1/00001234", c_rv[3], c_rd[3]);
    else n_pass++;
`else
    n_checks++;
    if (c_fl[1] !== 1'b1 || c_we[0] !== 4'h0 || c_rv[2] !== 1'b0 || c_rv[3] !== 1'b0)
      $display("FAIL wrap_fault got fault=%b we=%b rv2=%b rv3=%b exp 1/0000/0/0",
               c_fl[1], c_we[0], c_rv[2], c_rv[3]);
    else n_pass++;
`endif
  endtask

  task automatic test_fault;
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    n_checks++;
    if (c_fl[1] !== 1'b1 || c_fl[2] !== 1'b0 || c_rv[2] !== 1'b0 || c_rdy[1] !== 1'b1)
      $display("FAIL f3_011 got f1=%b f2=%b rv=%b rdy=%b exp 1/0/0/1", c_fl[1], c_fl[2], c_rv[2], c_rdy[1]);
    else n_pass++;
    issue(1'b1, 3'b100, 32'h0000_0044, 32'h0000_00AB);
    n_checks++;
    if (c_fl[1] !== 1'b1 || c_we[0] !== 4'h0)
      $display("FAIL sb_unsigned got fault=%b we=%b exp 1/0000", c_fl[1], c_we[0]);
    else n_pass++;
    issue(1'b0, 3'b100, 32'h0000_0044, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'h0) $display("FAIL fault_nowrite got %h exp 00000000", c_rd[2]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      model(1'b1, 3'b010, 32'h180 + 32'(4*i), 32'hC0DE_0000 + 32'(i));
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h180 + 32'(4*i); req_wdata = 32'hC0DE_0000 + 32'(i);
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL b2b_ready idx=%0d got %b exp 1", i, req_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 3'b010, 32'h180 + 32'(4*i), 32'h0);
      n_checks++;
      if (c_rd[2] !== 32'hC0DE_0000 + 32'(i))
        $display("FAIL b2b_data idx=%0d got %h exp %h", i, c_rd[2], 32'hC0DE_0000 + 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int unsigned n;
    // Load aborted while its data is in flight: no result pulse afterwards.
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rdata_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL rst_ld_abort got rv=%b ready=%b exp 0/0", rdata_valid, req_ready);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rdata_valid !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rst_ld_after got rv=%b rdata=%h exp 0/0", rdata_valid, rdata);
    else n_pass++;
`ifdef MEM_SPLIT_MISALIGNED_EN
    // Crossing store interrupted in its high-half cycle.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h143; req_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_if.WriteEnable !== 4'h0 || req_ready !== 1'b0)
      $display("FAIL rst_st_hi got we=%b ready=%b exp 0000/0", dmem_if.WriteEnable, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rmem[12'h143] = 8'hDD;
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h0000_0144, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'h0) $display("FAIL rst_hi_unwritten got %h exp 00000000", c_rd[2]);
    else n_pass++;
    issue(1'b0, 3'b100, 32'h0000_0143, 32'h0);
    n_checks++;
    if (c_rd[2] !== 32'h0000_00DD) $display("FAIL rst_lo_written got %h exp 000000dd", c_rd[2]);
    else n_pass++;
`endif
  endtask

  task automatic test_random;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          idx;
    for (int i = 0; i < 200; i++) begin
      w  = ($urandom_range(0, 2) == 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      a[11:0] = 12'($urandom_range(0, 63)) ^ (($urandom_range(0, 1) == 1) ? 12'hFC0 : 12'h000);
      wd = $urandom;
      issue(w, f3, a, wd);
      n_checks++;
      if (c_fl[1] !== exp_bad)
        $display("FAIL rnd_fault i=%0d w=%b f3=%0d a=%h got %b exp %b", i, w, f3, a, c_fl[1], exp_bad);
      else n_pass++;
      if (exp_bad) begin
        n_checks++;
        if (c_we[0] !== 4'h0) $display("FAIL rnd_fault_we i=%0d got %b exp 0000", i, c_we[0]);
        else n_pass++;
      end else if (!w) begin
        idx = exp_cross ? 3 : 2;
        n_checks++;
        if (c_rv[idx] !== 1'b1 || c_rd[idx] !== exp_rd)
          $display("FAIL rnd_load i=%0d f3=%0d a=%h got rv=%b rdata=%h exp 1/%h",
                   i, f3, a, c_rv[idx], c_rd[idx], exp_rd);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) rmem[i] = '0;
    dmem_if.data_in = '0;
    test_reset();
    test_aligned();
    test_byte_half();
    test_crossing();
    test_wrap();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
